// File: rtl/sdp_ram_be_pkg.sv
// Shared RAM types and the byte-enable merge used by the collision bypass.
// Widths are fixed at MAX_DATA here so one function serves every instance width.
package qcodec_ram_pkg;

   typedef enum logic {RAM_CLEAR, RAM_RUN} ram_state_e;

   localparam int MAX_DATA = 1024;
   localparam int MAX_IW   = $clog2(MAX_DATA);

   function automatic logic [MAX_DATA-1:0] byte_merge(
      input logic [MAX_DATA-1:0] old_w,
      input logic [MAX_DATA-1:0] new_w,
      input logic [MAX_DATA-1:0] be,
      input int                  byte_size
   );
      logic [MAX_DATA-1:0] w_res;
      w_res = old_w;
      for (int i = 0; i < MAX_DATA; i++) begin
         if (be[MAX_IW'(i / byte_size)]) w_res[MAX_IW'(i)] = new_w[MAX_IW'(i)];
      end
      return w_res;
   endfunction

endpackage

// File: rtl/sdp_ram_be_core.sv
// Bare byte-sliced SDP array: one RAM per byte lane, registered read, holds when idle.
// Read-first on a same-address write; the top resolves the collision.
module sdp_ram_be_core #(
   parameter int ADDR_SIZE = 9,
   parameter int DATA_SIZE = 72,
   parameter int BYTE_SIZE = 8
) (
   input  logic                           i_clk,
   input  logic                           i_we,
   input  logic [DATA_SIZE/BYTE_SIZE-1:0] i_wbe,
   input  logic [ADDR_SIZE-1:0]           i_waddr,
   input  logic [DATA_SIZE-1:0]           i_wdat,
   input  logic                           i_re,
   input  logic [ADDR_SIZE-1:0]           i_raddr,
   output logic [DATA_SIZE-1:0]           o_rdat
);
   localparam int NUM_BYTES = DATA_SIZE / BYTE_SIZE;
   localparam int DEPTH     = 1 << ADDR_SIZE;

   for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
      (* ram_style = "block" *) logic [BYTE_SIZE-1:0] r_mem [0:DEPTH-1];
      logic [BYTE_SIZE-1:0] r_q;

      always_ff @(posedge i_clk) begin
         if (i_we && i_wbe[g]) r_mem[i_waddr] <= i_wdat[g*BYTE_SIZE +: BYTE_SIZE];
         if (i_re) r_q <= r_mem[i_raddr];
      end

      assign o_rdat[g*BYTE_SIZE +: BYTE_SIZE] = r_q;
   end
endmodule

// File: rtl/sdp_ram_be.sv
// SDP RAM with byte enables, clear sweep after reset, write-first bypass; no backpressure.
// Read latency 1, or 2 with `SDP_RAM_BE_OREG_EN (extra output register after bypass mux).
module sdp_ram_be
   import qcodec_ram_pkg::*;
#(
   parameter int                   ADDR_SIZE  = 9,
   parameter int                   DATA_SIZE  = 72,
   parameter int                   BYTE_SIZE  = 8,
   parameter logic [DATA_SIZE-1:0] INIT_VALUE = '0
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   output logic                           o_init_done,
   input  logic                           i_wea,
   input  logic [DATA_SIZE/BYTE_SIZE-1:0] i_wbe,
   input  logic [ADDR_SIZE-1:0]           i_addra,
   input  logic [DATA_SIZE-1:0]           i_dina,
   input  logic                           i_reb,
   input  logic [ADDR_SIZE-1:0]           i_addrb,
   output logic [DATA_SIZE-1:0]           o_doutb,
   output logic                           o_doutb_vld
);
   localparam int NUM_BYTES = DATA_SIZE / BYTE_SIZE;

   if (DATA_SIZE % BYTE_SIZE != 0) begin : g_bad_width
      $error("sdp_ram_be: DATA_SIZE must be a multiple of BYTE_SIZE");
   end

   ram_state_e               r_state;
   logic [ADDR_SIZE-1:0]     r_clr_addr;
   logic                     r_init_done;
   logic                     r_rd_vld;
   logic                     r_col;
   logic [NUM_BYTES-1:0]     r_wbe;
   logic [DATA_SIZE-1:0]     r_dina;

   logic                     w_run, w_rd_acc, w_col;
   logic                     w_we;
   logic [NUM_BYTES-1:0]     w_wbe;
   logic [ADDR_SIZE-1:0]     w_waddr;
   logic [DATA_SIZE-1:0]     w_wdat, w_core_q, w_mux;

   assign w_run    = (r_state == RAM_RUN);
   assign w_rd_acc = w_run & i_reb;
   assign w_col    = w_rd_acc & i_wea & (i_addra == i_addrb);

   // The sweep owns the write port until every word holds INIT_VALUE.
   always_comb begin
      w_we    = i_wea;
      w_wbe   = i_wbe;
      w_waddr = i_addra;
      w_wdat  = i_dina;
      if (!w_run) begin
         w_we    = 1'b1;
         w_wbe   = '1;
         w_waddr = r_clr_addr;
         w_wdat  = INIT_VALUE;
      end
   end

   sdp_ram_be_core #(
      .ADDR_SIZE (ADDR_SIZE),
      .DATA_SIZE (DATA_SIZE),
      .BYTE_SIZE (BYTE_SIZE)
   ) u_core (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_wbe   (w_wbe),
      .i_waddr (w_waddr),
      .i_wdat  (w_wdat),
      .i_re    (w_rd_acc),
      .i_raddr (i_addrb),
      .o_rdat  (w_core_q)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= RAM_CLEAR;
         r_clr_addr  <= '0;
         r_init_done <= 1'b0;
         r_rd_vld    <= 1'b0;
         r_col       <= 1'b0;
      end else begin
         if (r_state == RAM_CLEAR) begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (&r_clr_addr) begin
               r_state     <= RAM_RUN;
               r_init_done <= 1'b1;
            end
         end
         r_rd_vld <= w_rd_acc;
         if (w_rd_acc) r_col <= w_col;
      end
   end

   // Write side of a collision travels with the read so the array itself stays read-first.
   always_ff @(posedge i_clk) begin
      if (w_rd_acc) begin
         r_wbe  <= i_wbe;
         r_dina <= i_dina;
      end
   end

   assign w_mux = r_col ? DATA_SIZE'(byte_merge(MAX_DATA'(w_core_q), MAX_DATA'(r_dina),
                                                MAX_DATA'(r_wbe), BYTE_SIZE))
                        : w_core_q;

   assign o_init_done = r_init_done;

`ifdef SDP_RAM_BE_OREG_EN
   logic [DATA_SIZE-1:0] r_dout;
   logic                 r_dout_vld;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_dout     <= '0;
         r_dout_vld <= 1'b0;
      end else begin
         r_dout_vld <= r_rd_vld;
         if (r_rd_vld) r_dout <= w_mux;
      end
   end

   assign o_doutb     = r_dout;
   assign o_doutb_vld = r_dout_vld;
`else
   logic r_have;

   // Array register is not reset, so doutb reads zero until the first read after reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)      r_have <= 1'b0;
      else if (w_rd_acc) r_have <= 1'b1;
   end

   assign o_doutb     = r_have ? w_mux : '0;
   assign o_doutb_vld = r_rd_vld;
`endif
endmodule
